// File: rtl/sample_collector_pkg.sv
// Shared types and constants for the sample collector and its FIFO.
package sample_collector_pkg;

  localparam int unsigned CNT_W  = 15;
  localparam int unsigned DATA_W = 16;

  // Register map, addr[7:0]
  localparam logic [7:0] REG_CTRL    = 8'd0;
  localparam logic [7:0] REG_STATUS  = 8'd1;
  localparam logic [7:0] REG_DATA_LO = 8'd2;
  localparam logic [7:0] REG_DATA_HI = 8'd3;

  // CTRL bit positions
  localparam int unsigned CTRL_RUN_BIT   = 0;
  localparam int unsigned CTRL_CLEAR_BIT = 1;

  // Fixed pattern a live responder places in bits [15:1]
  localparam logic [CNT_W-1:0] SAMPLE_MARKER = 15'h55E7;

  // Channel response as seen on sample_data
  typedef struct packed {
    logic             tag;     // [31] must be 0
    logic [CNT_W-1:0] count;   // [30:16]
    logic [CNT_W-1:0] marker;  // [15:1]
    logic             pin;     // [0]
  } response_t;

  // FIFO word; field order fixes the bit positions
  typedef struct packed {
    logic [7:0]       channel; // [31:24]
    logic [6:0]       rsvd_hi; // [23:17]
    logic             pin;     // [16]
    logic             rsvd_lo; // [15]
    logic [CNT_W-1:0] count;   // [14:0]
  } fifo_word_t;

  // Scanner states, one-hot
  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_REQ     = 4'b0010,
    ST_CAPTURE = 4'b0100,
    ST_STORE   = 4'b1000
  } scan_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count/flags and simultaneous push/pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  // Accept logic and next pointer/count; a full FIFO still takes a push when it pops
  always_comb begin
    do_pop   = pop_i && !empty_q && !clear_i;
    do_push  = push_i && (!full_q || do_pop) && !clear_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  // Pointer, count and flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/sample_collector.sv
// Round-robin poller for the shared sample_data bus; queues new samples for the host.
module sample_collector
  import sample_collector_pkg::*;
#(
  parameter logic [7:0]  POSITION     = 8'hF0,
  parameter int unsigned NUM_CHANNELS = 8,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [18:0] addr,
  input  logic [15:0] data_in,
  input  logic        data_wr,
  input  logic        data_rd,
  output logic [15:0] data_out,
  output logic        output_sample,
  output logic [7:0]  channel_select,
  input  logic [31:0] sample_data,
  output logic        fifo_nonempty
);

  localparam int unsigned CH_W    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int unsigned FIFO_CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned WORD_W  = $bits(fifo_word_t);

  // Scanner
  scan_state_e     state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  response_t       sample_q, sample_d;
  logic            known_q, known_d;
  logic            output_sample_q, output_sample_d;
  logic [7:0]      channel_select_q, channel_select_d;

  // Control / status
  logic              run_q, run_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] data_out_q, rdata_d;

  // Per-channel history
  logic [CNT_W-1:0]        last_cnt_q [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] seen_q;

  // Bus and datapath
  logic               bus_sel, wr_sel, rd_sel, ctrl_clear;
  logic [7:0]         reg_addr;
  logic               rsp_valid, rsp_new, chan_update, push_req, fifo_pop;
  fifo_word_t         push_word, fifo_head;
  logic [FIFO_CW-1:0] fifo_count;
  logic               fifo_full, fifo_empty;
  logic               unused_bits;

  // Scanner next state and the poll outputs registered alongside it
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    sample_d = sample_q;
    known_d  = known_q;
    unique case (state_q)
      ST_IDLE: begin
        if (run_q) begin
          state_d = ST_REQ;
          ch_d    = '0;
        end
      end
      ST_REQ: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        sample_d = sample_data;
        // Undriven or contended bus shows up as X/Z in simulation; silicon never sees it
        known_d  = !$isunknown(sample_data);
        state_d  = ST_STORE;
      end
      ST_STORE: begin
        ch_d    = (ch_q == CH_W'(NUM_CHANNELS - 1)) ? '0 : ch_q + CH_W'(1);
        state_d = run_q ? ST_REQ : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    output_sample_d  = (state_d == ST_REQ);
    channel_select_d = (state_d == ST_IDLE) ? 8'h00 : 8'(ch_d);
  end

  // Scanner registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      ch_q             <= '0;
      sample_q         <= '0;
      known_q          <= 1'b0;
      output_sample_q  <= 1'b0;
      channel_select_q <= '0;
    end else begin
      state_q          <= state_d;
      ch_q             <= ch_d;
      sample_q         <= sample_d;
      known_q          <= known_d;
      output_sample_q  <= output_sample_d;
      channel_select_q <= channel_select_d;
    end
  end

  // Bus decode, validation, push/pop, overflow and read mux
  always_comb begin
    bus_sel    = enable && (addr[15:8] == POSITION);
    wr_sel     = bus_sel && data_wr;
    rd_sel     = bus_sel && data_rd;
    reg_addr   = addr[7:0];
    ctrl_clear = wr_sel && (reg_addr == REG_CTRL) && data_in[CTRL_CLEAR_BIT];

    rsp_valid   = known_q && !sample_q.tag && (sample_q.marker == SAMPLE_MARKER);
    rsp_new     = !seen_q[ch_q] || (last_cnt_q[ch_q] != sample_q.count);
    chan_update = (state_q == ST_STORE) && rsp_valid && rsp_new && !ctrl_clear;
    push_req    = chan_update;

    push_word         = '0;
    push_word.channel = 8'(ch_q);
    push_word.pin     = sample_q.pin;
    push_word.count   = sample_q.count;

    fifo_pop = rd_sel && (reg_addr == REG_DATA_HI) && !fifo_empty;

    run_d = run_q;
    if (wr_sel && (reg_addr == REG_CTRL)) run_d = data_in[CTRL_RUN_BIT];

    ovf_d = ovf_q;
    if (ctrl_clear)                                ovf_d = 1'b0;
    else if (push_req && fifo_full && !fifo_pop)   ovf_d = 1'b1;

    rdata_d = '0;
    if (rd_sel) begin
      case (reg_addr)
        REG_CTRL:    rdata_d = {15'b0, run_q};
        REG_STATUS:  rdata_d = {ovf_q, run_q, 6'b0, 8'(fifo_count)};
        REG_DATA_LO: rdata_d = fifo_head[15:0];
        REG_DATA_HI: rdata_d = fifo_empty ? 16'h0000 : fifo_head[31:16];
        default:     rdata_d = '0;
      endcase
    end
  end

  // Control, status and read-data registers
  always_ff @(posedge clk) begin
    if (reset) begin
      run_q      <= 1'b0;
      ovf_q      <= 1'b0;
      data_out_q <= '0;
    end else begin
      run_q      <= run_d;
      ovf_q      <= ovf_d;
      data_out_q <= rdata_d;
    end
  end

  // Per-channel seen flags and last count
  always_ff @(posedge clk) begin
    if (reset || ctrl_clear) begin
      seen_q <= '0;
    end else if (chan_update) begin
      seen_q[ch_q]     <= 1'b1;
      last_cnt_q[ch_q] <= sample_q.count;
    end
  end

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear_i (ctrl_clear),
    .push_i  (push_req),
    .data_i  (push_word),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign data_out       = data_out_q;
  assign output_sample  = output_sample_q;
  assign channel_select = channel_select_q;
  assign fifo_nonempty  = !fifo_empty;
  assign unused_bits    = ^{addr[18:16], data_in[15:2]};

endmodule
